btn_conditioner_n: RTL and testbench

- Multi-channel input conditioner for push-buttons and slide switches.
- Replaces per-input hand-wired flip-flop chains, edge detectors and toggle flip-flops.
- Each channel has:
  - an N-stage synchroniser,
  - a counter-based debouncer,
  - registered rising/falling edge pulses,
  - a press-toggled state bit with synchronous clear.
- Sits between board pins and the FSM/counter logic of user designs.

---
 rtl/btn_conditioner_n.sv | 91 +++++++++
 tb/tb_btn_conditioner_n.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner_n.sv
// Multi-channel push-button / switch conditioner: synchroniser, counter debouncer,
// registered edge pulses and a press-toggled state bit per channel.
module btn_conditioner_n #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT      = 100000,
  parameter int CNT_W       = $clog2(DB_CNT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] btn_in,
  input  logic [CH-1:0] toggle_clr,
  output logic [CH-1:0] db_out,
  output logic [CH-1:0] p_edge,
  output logic [CH-1:0] n_edge,
  output logic [CH-1:0] toggle
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   db_r;
    logic                   db_nxt_s;
    logic                   p_r;
    logic                   n_r;
    logic                   tog_r;
    logic                   s_i;

    assign s_i = sync_r[SYNC_STAGES-1];

    // Synchroniser shift chain for the raw pin
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_r <= '0;
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], btn_in[g]};
      end
    end

    // Debounce decision: a full run of DB_CNT disagreeing cycles flips the level
    always_comb begin
      cnt_nxt_s = '0;
      db_nxt_s  = db_r;
      if (s_i == db_r) begin
        cnt_nxt_s = '0;
      end else if (cnt_r == CNT_LAST) begin
        cnt_nxt_s = '0;
        db_nxt_s  = ~db_r;
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end
    end

    // Debounce state; edge pulses are registered from the level transition itself
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r <= '0;
        db_r  <= 1'b0;
        p_r   <= 1'b0;
        n_r   <= 1'b0;
      end else begin
        cnt_r <= cnt_nxt_s;
        db_r  <= db_nxt_s;
        p_r   <= db_nxt_s & ~db_r;
        n_r   <= ~db_nxt_s & db_r;
      end
    end

    // Toggle bit: clear has priority and swallows a coincident press
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tog_r <= 1'b0;
      end else if (toggle_clr[g]) begin
        tog_r <= 1'b0;
      end else if (p_r) begin
        tog_r <= ~tog_r;
      end else begin
        tog_r <= tog_r;
      end
    end

    assign db_out[g] = db_r;
    assign p_edge[g] = p_r;
    assign n_edge[g] = n_r;
    assign toggle[g] = tog_r;
  end

endmodule

// File: tb/tb_btn_conditioner_n.sv
// Self-checking bench for btn_conditioner_n (CH=2, SYNC_STAGES=2, DB_CNT=4):
// per-cycle scoreboard against a behavioural model plus directed timing checks.
module tb_btn_conditioner_n;
  localparam int CH = 2;
  localparam int SS = 2;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] btn_in = '0;
  logic [CH-1:0] toggle_clr = '0;
  logic [CH-1:0] db_out, p_edge, n_edge, toggle;

  btn_conditioner_n #(.CH(CH), .SYNC_STAGES(SS), .DB_CNT(DB)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .toggle_clr(toggle_clr),
    .db_out(db_out), .p_edge(p_edge), .n_edge(n_edge), .toggle(toggle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] db;
    logic [CH-1:0] p;
    logic [CH-1:0] n;
    logic [CH-1:0] tg;
  } obs_t;

  int   n_chk = 0;
  int   n_err = 0;
  obs_t exp_q[$];
  obs_t last;
  int   p0_cnt, n0_cnt;
  logic ch1_moved;

  // Behavioural model: sample history and disagreement run length per channel
  logic          m_hist [CH][SS];
  int            m_run  [CH];
  logic [CH-1:0] m_db, m_p, m_n, m_tg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < SS; k++) m_hist[c][k] = 1'b0;
      m_run[c] = 0;
    end
    m_db = '0; m_p = '0; m_n = '0; m_tg = '0;
  endtask

  task automatic model_edge(input logic [CH-1:0] b, input logic [CH-1:0] c);
    logic [CH-1:0] nd;
    nd   = m_db;
    m_tg = (m_tg ^ m_p) & ~c;
    for (int ch = 0; ch < CH; ch++) begin
      if (m_hist[ch][SS-1] != m_db[ch]) m_run[ch] = m_run[ch] + 1;
      else m_run[ch] = 0;
      if (m_run[ch] == DB) begin
        nd[ch]    = ~m_db[ch];
        m_run[ch] = 0;
      end
      for (int k = SS - 1; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
      m_hist[ch][0] = b[ch];
    end
    m_p  = nd & ~m_db;
    m_n  = ~nd & m_db;
    m_db = nd;
  endtask

  task automatic step(input logic [CH-1:0] b, input logic [CH-1:0] c);
    obs_t e;
    btn_in     = b;
    toggle_clr = c;
    model_edge(b, c);
    exp_q.push_back({m_db, m_p, m_n, m_tg});
    @(posedge clk); #1;
    last = {db_out, p_edge, n_edge, toggle};
    e = exp_q.pop_front();
    chk("scoreboard", last, e);
    if (last.p[0]) p0_cnt++;
    if (last.n[0]) n0_cnt++;
    if (last.db[1] | last.p[1] | last.n[1] | last.tg[1]) ch1_moved = 1'b1;
  endtask

  task automatic do_reset(input logic [CH-1:0] b);
    btn_in     = b;
    toggle_clr = '0;
    rst_n      = 1'b0;
    #1;
    chk("reset_immediate", {db_out, p_edge, n_edge, toggle}, 8'h00);
    @(posedge clk); #1;
    chk("reset_held", {db_out, p_edge, n_edge, toggle}, 8'h00);
    model_reset();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    p0_cnt = 0; n0_cnt = 0; ch1_moved = 1'b0;

    // Reset release with both buttons already high
    do_reset(2'b11);
    for (int i = 0; i < 5; i++) step(2'b11, 2'b00);
    chk("rel_db_before", db_out, 2'b00);
    step(2'b11, 2'b00);
    chk("rel_db_edge6", db_out, 2'b11);
    chk("rel_p_edge6", p_edge, 2'b11);
    chk("rel_tg_edge6", toggle, 2'b00);
    step(2'b11, 2'b00);
    chk("rel_p_edge7", p_edge, 2'b00);
    chk("rel_tg_edge7", toggle, 2'b11);

    // Clean press then release on ch0
    do_reset(2'b00);
    for (int i = 0; i < 5; i++) step(2'b01, 2'b00);
    chk("press_db_before", db_out[0], 1'b0);
    step(2'b01, 2'b00);
    chk("press_db", db_out[0], 1'b1);
    chk("press_p", p_edge[0], 1'b1);
    step(2'b01, 2'b00);
    chk("press_tg", toggle[0], 1'b1);
    chk("press_p_width", p_edge[0], 1'b0);
    for (int i = 0; i < 5; i++) step(2'b00, 2'b00);
    chk("rls_db_before", db_out[0], 1'b1);
    step(2'b00, 2'b00);
    chk("rls_db", db_out[0], 1'b0);
    chk("rls_n", n_edge[0], 1'b1);
    step(2'b00, 2'b00);
    chk("rls_n_width", n_edge[0], 1'b0);
    chk("rls_tg_kept", toggle[0], 1'b1);

    // Bounce on ch1: 1,0,1,1,0,1 then stable high
    do_reset(2'b00);
    begin
      logic [5:0] pat;
      logic       quiet;
      pat   = 6'b101101;
      quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
        step({pat[5-i], 1'b0}, 2'b00);
        if (last.db[1] | last.p[1] | last.n[1]) quiet = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        step(2'b10, 2'b00);
        if (last.db[1] | last.p[1] | last.n[1]) quiet = 1'b0;
      end
      chk("bounce_quiet", quiet, 1'b1);
      step(2'b10, 2'b00);
      chk("bounce_db_rise", db_out[1], 1'b1);
      chk("bounce_p", p_edge[1], 1'b1);
    end

    // Three press/release cycles on ch0, ch1 idle
    do_reset(2'b00);
    p0_cnt = 0; n0_cnt = 0; ch1_moved = 1'b0;
    begin
      logic [2:0] tg_seq;
      for (int r = 0; r < 3; r++) begin
        for (int i = 0; i < 8; i++) step(2'b01, 2'b00);
        tg_seq[2-r] = toggle[0];
        for (int i = 0; i < 8; i++) step(2'b00, 2'b00);
      end
      chk("multi_tg_seq", tg_seq, 3'b101);
    end
    chk("multi_p_count", p0_cnt, 3);
    chk("multi_n_count", n0_cnt, 3);
    chk("multi_ch1_idle", ch1_moved, 1'b0);

    // Clear coincident with p_edge, then clear with no press
    do_reset(2'b00);
    for (int i = 0; i < 8; i++) step(2'b01, 2'b00);
    for (int i = 0; i < 8; i++) step(2'b00, 2'b00);
    chk("clr_pre_tg", toggle[0], 1'b1);
    for (int i = 0; i < 6; i++) step(2'b01, 2'b00);
    chk("clr_p_seen", p_edge[0], 1'b1);
    step(2'b01, 2'b01);
    chk("clr_wins", toggle[0], 1'b0);
    step(2'b01, 2'b00);
    chk("clr_no_reflip", toggle[0], 1'b0);
    for (int i = 0; i < 8; i++) step(2'b00, 2'b00);
    for (int i = 0; i < 8; i++) step(2'b01, 2'b00);
    chk("clr2_pre_tg", toggle[0], 1'b1);
    step(2'b01, 2'b01);
    chk("clr_idle", toggle[0], 1'b0);

    // Reset in the middle of a debounce count
    do_reset(2'b00);
    for (int i = 0; i < 5; i++) step(2'b01, 2'b00);
    do_reset(2'b01);
    for (int i = 0; i < 5; i++) step(2'b01, 2'b00);
    chk("midrst_db_before", db_out[0], 1'b0);
    step(2'b01, 2'b00);
    chk("midrst_db_rise", db_out[0], 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
